// File: rtl/key_move_pulser.sv
// Purpose : debounce two raw push-buttons and turn them into single-cycle step pulses
//           with typematic auto-repeat (initial pulse, long delay, then periodic pulses).
// Latency : raw rise sampled at edge 0 -> pulse high during the cycle after edge DEBOUNCE_CYCLES+3.
// Backpressure: none; the consumer must take every pulse. A coincident down pulse is dropped.
// Ports   : clk          - system clock, rising edge
//           rst          - synchronous active-high reset
//           key_up_raw   - asynchronous bouncing "up" button level (1 = pressed)
//           key_down_raw - asynchronous bouncing "down" button level (1 = pressed)
//           key1         - registered one-cycle "move up one step" pulse
//           key2         - registered one-cycle "move down one step" pulse
module key_move_pulser #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 40000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_up_raw,
    input  logic key_down_raw,
    output logic key1,
    output logic key2
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // index 0 = up, index 1 = down
    logic [1:0] w_raw;
    logic [1:0] w_pulse;

    assign w_raw = {key_down_raw, key_up_raw};

    for (genvar g = 0; g < 2; g++) begin : g_key
        logic             r_sync1;
        logic             r_sync2;
        logic             r_deb;
        logic             r_deb_d;
        logic [DB_W-1:0]  r_db_cnt;
        state_t           r_state;
        state_t           w_state_nxt;
        logic [RPT_W-1:0] r_rpt_cnt;
        logic [RPT_W-1:0] w_rpt_cnt_nxt;
        logic             r_pulse;
        logic             w_pulse_nxt;
        logic             w_rise;

        // Synchronizer and debounce. The counter only runs while the synchronized
        // level disagrees with the accepted level; any agreement wipes it, so a
        // bounce restarts the full stability window.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_deb    <= 1'b0;
                r_deb_d  <= 1'b0;
                r_db_cnt <= '0;
            end else begin
                r_sync1 <= w_raw[g];
                r_sync2 <= r_sync1;
                r_deb_d <= r_deb;
                if (r_sync2 == r_deb) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_LAST) begin
                    r_deb    <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

        // r_deb_d clears in reset, so a key held through reset looks like a fresh press.
        assign w_rise = r_deb & ~r_deb_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= ST_IDLE;
                r_rpt_cnt <= '0;
                r_pulse   <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_rpt_cnt <= w_rpt_cnt_nxt;
                r_pulse   <= w_pulse_nxt;
            end
        end

        // Release is checked before terminal count so a release landing on the
        // terminal-count cycle never produces a stray pulse.
        always_comb begin
            w_state_nxt   = r_state;
            w_rpt_cnt_nxt = r_rpt_cnt;
            w_pulse_nxt   = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_pulse_nxt   = 1'b1;
                        w_rpt_cnt_nxt = '0;
                        w_state_nxt   = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (!r_deb) begin
                        w_rpt_cnt_nxt = '0;
                        w_state_nxt   = ST_IDLE;
                    end else if (r_rpt_cnt == DELAY_LAST) begin
                        w_pulse_nxt   = 1'b1;
                        w_rpt_cnt_nxt = '0;
                        w_state_nxt   = ST_REPEAT;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!r_deb) begin
                        w_rpt_cnt_nxt = '0;
                        w_state_nxt   = ST_IDLE;
                    end else if (r_rpt_cnt == PERIOD_LAST) begin
                        w_pulse_nxt   = 1'b1;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    w_rpt_cnt_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                end
            endcase
        end

        assign w_pulse[g] = r_pulse;
    end

    // Up wins a collision; the down pulse is discarded rather than delayed so
    // both repeat timelines stay on their own schedule.
    always_ff @(posedge clk) begin
        if (rst) begin
            key1 <= 1'b0;
            key2 <= 1'b0;
        end else begin
            key1 <= w_pulse[0];
            key2 <= w_pulse[1] & ~w_pulse[0];
        end
    end

endmodule

// File: tb/tb_key_move_pulser.sv
module tb_key_move_pulser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_up_raw = 1'b0;
    logic key_down_raw = 1'b0;
    logic key1;
    logic key2;

    int checks = 0;
    int errors = 0;

    key_move_pulser #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_up_raw(key_up_raw),
        .key_down_raw(key_down_raw),
        .key1(key1),
        .key2(key2)
    );

    always #5 clk = ~clk;

    // Cycle n means the cycle after rising edge n; edge 0 is the first edge that
    // samples the new raw level. Inputs change and outputs are sampled on negedges.

    task automatic apply_reset();
        key_up_raw   = 1'b0;
        key_down_raw = 1'b0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain();
        key_up_raw   = 1'b0;
        key_down_raw = 1'b0;
        repeat (30) @(negedge clk);
        apply_reset();
    endtask

    // Outputs low under reset; key held through reset deassertion is a new press.
    task automatic test_reset();
        logic exp;
        rst        = 1'b1;
        key_up_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (key1 !== 1'b0 || key2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d key1=%b key2=%b expected 0 0", i, key1, key2);
            end
        end
        rst = 1'b0;
        for (int n = 0; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            exp = (n == 7);
            checks++;
            if (key1 !== exp || key2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_release cycle %0d key1=%b key2=%b expected %b 0", n, key1, key2, exp);
            end
        end
        drain();
    endtask

    // Clean press held: initial pulse, delayed repeat, periodic repeat.
    task automatic test_auto_repeat();
        logic exp;
        key_up_raw = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            exp = (n == 7 || n == 27 || n == 35);
            checks++;
            if (key1 !== exp || key2 !== 1'b0) begin
                errors++;
                $display("FAIL auto_repeat cycle %0d key1=%b key2=%b expected %b 0", n, key1, key2, exp);
            end
        end
        drain();
    endtask

    // Single-cycle toggling never accumulates enough stability.
    task automatic test_bounce();
        for (int n = 0; n < 30; n++) begin
            key_down_raw = (n < 6) ? ((n % 2) == 0) : 1'b0;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (key1 !== 1'b0 || key2 !== 1'b0) begin
                errors++;
                $display("FAIL bounce cycle %0d key1=%b key2=%b expected 0 0", n, key1, key2);
            end
        end
        drain();
    endtask

    // A one-cycle dropout restarts the debounce window from the final rise (edge 4).
    task automatic test_glitch_restart();
        logic exp;
        for (int n = 0; n < 20; n++) begin
            key_up_raw = (n == 3) ? 1'b0 : 1'b1;
            @(posedge clk);
            @(negedge clk);
            exp = (n == 11);
            checks++;
            if (key1 !== exp || key2 !== 1'b0) begin
                errors++;
                $display("FAIL glitch_restart cycle %0d key1=%b key2=%b expected %b 0", n, key1, key2, exp);
            end
        end
        drain();
    endtask

    // Both keys together: up wins every collision, down is dropped.
    task automatic test_simultaneous();
        logic exp;
        key_up_raw   = 1'b1;
        key_down_raw = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            exp = (n == 7 || n == 27 || n == 35);
            checks++;
            if (key1 !== exp || key2 !== 1'b0) begin
                errors++;
                $display("FAIL simultaneous cycle %0d key1=%b key2=%b expected %b 0", n, key1, key2, exp);
            end
            checks++;
            if ((key1 & key2) !== 1'b0) begin
                errors++;
                $display("FAIL simultaneous_both cycle %0d key1&key2=%b expected 0", n, key1 & key2);
            end
        end
        drain();
    endtask

    // Release from edge 36 debounces low in the cycle after edge 41, exactly when
    // the repeat counter is at terminal count: the cycle-43 pulse must not appear.
    // A fresh press afterwards proves the FSM went back to IDLE.
    task automatic test_release_on_tc();
        logic exp;
        for (int n = 0; n < 60; n++) begin
            key_up_raw = (n < 36);
            @(posedge clk);
            @(negedge clk);
            exp = (n == 7 || n == 27 || n == 35);
            checks++;
            if (key1 !== exp || key2 !== 1'b0) begin
                errors++;
                $display("FAIL release_tc cycle %0d key1=%b key2=%b expected %b 0", n, key1, key2, exp);
            end
        end
        key_up_raw = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            @(negedge clk);
            exp = (n == 7);
            checks++;
            if (key1 !== exp || key2 !== 1'b0) begin
                errors++;
                $display("FAIL release_tc_repress cycle %0d key1=%b key2=%b expected %b 0", n, key1, key2, exp);
            end
        end
        drain();
    endtask

    // Reset at edge 34 in REPEAT kills the cycle-35 pulse; key still held, so the
    // next pulse is 7 cycles after first non-reset edge 35 -> cycle 42.
    task automatic test_reset_mid_repeat();
        logic exp;
        key_up_raw = 1'b1;
        for (int n = 0; n < 56; n++) begin
            rst = (n == 34);
            @(posedge clk);
            @(negedge clk);
            exp = (n == 7 || n == 27 || n == 42);
            checks++;
            if (key1 !== exp || key2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_repeat cycle %0d key1=%b key2=%b expected %b 0", n, key1, key2, exp);
            end
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_auto_repeat();
        test_bounce();
        test_glitch_restart();
        test_simultaneous();
        test_release_on_tc();
        test_reset_mid_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
